free_list: RTL and testbench
============================

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter NUM_PHYS, default 64, number of physical registers.
REQ-002 SHALL have parameter NUM_ARCH, default 34, number of architectural registers, including HI/LO.
REQ-003 SHALL have parameter DEPTH, default 32, free-list entries; power of two, at least NUM_PHYS-NUM_ARCH.
REQ-004 CLK  input  1  clock; all state updates on rising edge.
REQ-005 RESET  input  1  reset; asynchronous, active-high.
REQ-006 ALLOC_IN  input  1  rename stage consumes the head ID this cycle.
REQ-007 STALL_IN  input  1  rename stalled; masks ALLOC_IN.
REQ-008 RELEASE_IN  input  1  retirement returns a physical ID.
REQ-009 RELEASE_ID_IN  input  6  physical ID being returned (previous mapping of the retired destination).
REQ-010 COMMIT_ALLOC_IN  input  1  retiring instruction held an allocated destination.
REQ-011 FLUSH_IN  input  1  misprediction/exception recovery.
REQ-012 RegID_OUT  output  6  head entry, combinational from storage.
REQ-013 EMPTY_OUT  output  1  no free ID; rename stage stalls.
REQ-014 FREE_COUNT_OUT  output  6  number of free IDs.
REQ-015 OVERFLOW_OUT  output  1  sticky error: release attempted while full.

Function
REQ-016 SHALL hold a circular buffer of DEPTH 6-bit entries with three 6-bit pointers (5-bit index plus wrap bit): rptr (speculative head), cptr (committed head), wptr (tail).
REQ-017 SHALL compute FREE_COUNT_OUT = wptr - rptr, modulo 64; EMPTY_OUT = (count == 0); full = (count == DEPTH).
REQ-018 SHALL drive RegID_OUT = entry[rptr index] every cycle, whether or not the list is empty.
REQ-019 SHALL treat an allocation as granted when ALLOC_IN & !STALL_IN & !EMPTY_OUT & !FLUSH_IN; a grant increments rptr by 1.
REQ-020 SHALL ignore a non-granted ALLOC_IN with no state change; ALLOC_IN while empty sets no error.
REQ-021 SHALL, on RELEASE_IN when not full, write RELEASE_ID_IN to entry[wptr index] and increment wptr.
REQ-022 SHALL, on RELEASE_IN when full, drop the write and set OVERFLOW_OUT; OVERFLOW_OUT clears only on RESET.
REQ-023 SHALL increment cptr on COMMIT_ALLOC_IN.
REQ-024 SHALL, on FLUSH_IN, set rptr to the cptr value after this cycle's commit: cptr+1 if COMMIT_ALLOC_IN, else cptr.
REQ-025 SHALL, for grant and release in the same cycle, apply both; a release into an empty list is not bypassed, and RegID_OUT shows the released ID the next cycle.
REQ-026 SHALL, for flush and release in the same cycle, apply both; flush has priority over allocation.
REQ-027 SHALL allow the pointer index to wrap from DEPTH-1 to 0, with the wrap bit toggling.
REQ-028 SHALL make every output change visible one cycle after the causing edge, except RegID_OUT and the count, which follow the pointers combinationally.

Reset
REQ-029 SHALL, while RESET is high, set entry[i] = NUM_ARCH + i for i < NUM_PHYS-NUM_ARCH (34..63) and all other entries to 0.
REQ-030 SHALL reset rptr = cptr = 0 and wptr = NUM_PHYS-NUM_ARCH (30).
REQ-031 SHALL therefore reset outputs to RegID_OUT = 34, FREE_COUNT_OUT = 30, EMPTY_OUT = 0, OVERFLOW_OUT = 0.
REQ-032 SHALL abandon any in-flight operation on RESET assertion mid-cycle; no partial update survives.

Structure
REQ-033 SHALL take NUM_PHYS, NUM_ARCH, DEPTH and the physical-ID width (6) from the shared rename package also used by the rename table and the retirement table.
REQ-034 SHALL be a single module with no sub-modules; storage is a register array, not inferred RAM, to allow the reset image.

Verification
REQ-035 Reset, then 30 granted allocations -> RegID_OUT sequence 34..63, then EMPTY_OUT=1 and FREE_COUNT_OUT=0.
REQ-036 From empty, grant + RELEASE_ID_IN=5 in the same cycle -> no grant; next cycle RegID_OUT=5, count=1.
REQ-037 Allocate 34,35,36; COMMIT_ALLOC_IN once; FLUSH_IN -> RegID_OUT=35, count=29.
REQ-038 FLUSH_IN and COMMIT_ALLOC_IN in the same cycle after 3 allocations and 1 prior commit -> RegID_OUT=36.
REQ-039 40 alternating release/allocate cycles -> pointers wrap past 31 and IDs return in FIFO order.
REQ-040 Release 2 extra IDs at reset (count=32), then a third release -> OVERFLOW_OUT=1 and count stays 32.

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared rename-stage constants: physical/architectural register counts,
// free-list depth and physical register ID width. Also used by the rename
// table and the retirement table.
package free_list_pkg;

    localparam int unsigned RN_NUM_PHYS = 64;  // physical registers
    localparam int unsigned RN_NUM_ARCH = 34;  // architectural registers incl. HI/LO
    localparam int unsigned RN_DEPTH    = 32;  // free-list entries (power of two)
    localparam int unsigned RN_PHYS_W   = 6;   // physical register ID width

    typedef logic [RN_PHYS_W-1:0] phys_id_t;

endpackage

// File: rtl/free_list.sv
// Physical register free list for the rename stage.
//
// Circular buffer of physical register IDs with a speculative head (rptr),
// a committed head (cptr) and a tail (wptr). Rename allocates from rptr,
// retirement advances cptr and returns old mappings at wptr, and a flush
// rewinds rptr to cptr so that speculatively allocated IDs become free again.
//
// Ports:
//   CLK             clock, rising edge
//   RESET           asynchronous active-high reset; loads the reset image
//   ALLOC_IN        rename consumes the head ID this cycle
//   STALL_IN        rename stalled; masks ALLOC_IN
//   RELEASE_IN      retirement returns RELEASE_ID_IN to the tail
//   RELEASE_ID_IN   physical ID being returned
//   COMMIT_ALLOC_IN retiring instruction held an allocated destination
//   FLUSH_IN        recovery; rewinds speculative head to committed head
//   RegID_OUT       head entry, combinational from storage
//   EMPTY_OUT       no free ID available
//   FREE_COUNT_OUT  number of free IDs
//   OVERFLOW_OUT    sticky: release attempted while full
module free_list
    import free_list_pkg::*;
#(
    parameter int unsigned NUM_PHYS = RN_NUM_PHYS,
    parameter int unsigned NUM_ARCH = RN_NUM_ARCH,
    parameter int unsigned DEPTH    = RN_DEPTH
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 ALLOC_IN,
    input  logic                 STALL_IN,
    input  logic                 RELEASE_IN,
    input  logic [RN_PHYS_W-1:0] RELEASE_ID_IN,
    input  logic                 COMMIT_ALLOC_IN,
    input  logic                 FLUSH_IN,
    output logic [RN_PHYS_W-1:0] RegID_OUT,
    output logic                 EMPTY_OUT,
    output logic [RN_PHYS_W-1:0] FREE_COUNT_OUT,
    output logic                 OVERFLOW_OUT
);

    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam int unsigned PTR_W     = IDX_W + 1;  // index plus wrap bit
    localparam int unsigned INIT_FREE = NUM_PHYS - NUM_ARCH;

    typedef logic [PTR_W-1:0] ptr_t;

    phys_id_t mem_q [DEPTH];
    ptr_t     rptr_q, rptr_d;
    ptr_t     cptr_q, cptr_d;
    ptr_t     wptr_q, wptr_d;
    logic     ovf_q, ovf_d;

    ptr_t     count;
    logic     empty;
    logic     full;
    logic     grant;
    logic     rel_ok;

    always_comb begin
        // Modular difference; the wrap bit disambiguates full from empty.
        count  = wptr_q - rptr_q;
        empty  = (count == '0);
        full   = (count == ptr_t'(DEPTH));
        grant  = ALLOC_IN & ~STALL_IN & ~empty & ~FLUSH_IN;
        rel_ok = RELEASE_IN & ~full;

        cptr_d = COMMIT_ALLOC_IN ? cptr_q + ptr_t'(1) : cptr_q;

        // Flush rewinds to the committed head including this cycle's commit.
        if (FLUSH_IN) begin
            rptr_d = cptr_d;
        end else if (grant) begin
            rptr_d = rptr_q + ptr_t'(1);
        end else begin
            rptr_d = rptr_q;
        end

        wptr_d = rel_ok ? wptr_q + ptr_t'(1) : wptr_q;
        ovf_d  = ovf_q | (RELEASE_IN & full);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rptr_q <= '0;
            cptr_q <= '0;
            wptr_q <= ptr_t'(INIT_FREE);
            ovf_q  <= 1'b0;
        end else begin
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
            wptr_q <= wptr_d;
            ovf_q  <= ovf_d;
        end
    end

    // Register array rather than RAM so the reset image can be loaded.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= (i < int'(INIT_FREE)) ? phys_id_t'(int'(NUM_ARCH) + i) : '0;
            end
        end else if (rel_ok) begin
            mem_q[wptr_q[IDX_W-1:0]] <= RELEASE_ID_IN;
        end
    end

    // Head is driven even when empty; consumers gate on EMPTY_OUT.
    assign RegID_OUT      = mem_q[rptr_q[IDX_W-1:0]];
    assign EMPTY_OUT      = empty;
    assign FREE_COUNT_OUT = RN_PHYS_W'(count);
    assign OVERFLOW_OUT   = ovf_q;

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list. The reference model tracks the free
// IDs as a FIFO queue, speculatively allocated IDs as a second queue and
// retired IDs available for release as a pool.
module tb_free_list;

    localparam int DEPTH = 32;

    logic       CLK;
    logic       RESET;
    logic       ALLOC_IN;
    logic       STALL_IN;
    logic       RELEASE_IN;
    logic [5:0] RELEASE_ID_IN;
    logic       COMMIT_ALLOC_IN;
    logic       FLUSH_IN;
    logic [5:0] RegID_OUT;
    logic       EMPTY_OUT;
    logic [5:0] FREE_COUNT_OUT;
    logic       OVERFLOW_OUT;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [5:0] free_q[$];
    logic [5:0] inflight_q[$];
    logic [5:0] pool_q[$];
    logic       m_ovf;

    free_list dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .ALLOC_IN       (ALLOC_IN),
        .STALL_IN       (STALL_IN),
        .RELEASE_IN     (RELEASE_IN),
        .RELEASE_ID_IN  (RELEASE_ID_IN),
        .COMMIT_ALLOC_IN(COMMIT_ALLOC_IN),
        .FLUSH_IN       (FLUSH_IN),
        .RegID_OUT      (RegID_OUT),
        .EMPTY_OUT      (EMPTY_OUT),
        .FREE_COUNT_OUT (FREE_COUNT_OUT),
        .OVERFLOW_OUT   (OVERFLOW_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic model_reset();
        free_q.delete();
        inflight_q.delete();
        pool_q.delete();
        for (int i = 0; i < 30; i++) free_q.push_back(6'(34 + i));
        m_ovf = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model, return at edge + 1.
    task automatic drive(input logic a, input logic s, input logic r, input logic [5:0] rid,
                         input logic c, input logic f);
        int   pre;
        logic g;
        ALLOC_IN        = a;
        STALL_IN        = s;
        RELEASE_IN      = r;
        RELEASE_ID_IN   = rid;
        COMMIT_ALLOC_IN = c;
        FLUSH_IN        = f;
        pre = free_q.size();
        g   = a && !s && (pre != 0) && !f;
        if (c && inflight_q.size() > 0) pool_q.push_back(inflight_q.pop_front());
        if (g) inflight_q.push_back(free_q.pop_front());
        if (f) begin
            free_q = {inflight_q, free_q};
            inflight_q.delete();
        end
        if (r) begin
            if (pre == DEPTH) m_ovf = 1'b1;
            else free_q.push_back(rid);
        end
        @(posedge CLK);
        #1;
        ALLOC_IN        = 1'b0;
        STALL_IN        = 1'b0;
        RELEASE_IN      = 1'b0;
        RELEASE_ID_IN   = '0;
        COMMIT_ALLOC_IN = 1'b0;
        FLUSH_IN        = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        ALLOC_IN = 0; STALL_IN = 0; RELEASE_IN = 0; RELEASE_ID_IN = 0;
        COMMIT_ALLOC_IN = 0; FLUSH_IN = 0;
        do_reset();
        total++; if (RegID_OUT !== 6'd34) begin bad++; $display("FAIL reset_regid got=%0d exp=34", RegID_OUT); end
        total++; if (FREE_COUNT_OUT !== 6'd30) begin bad++; $display("FAIL reset_count got=%0d exp=30", FREE_COUNT_OUT); end
        total++; if (EMPTY_OUT !== 1'b0) begin bad++; $display("FAIL reset_empty got=%0b exp=0", EMPTY_OUT); end
        total++; if (OVERFLOW_OUT !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", OVERFLOW_OUT); end
        // Reset asserted mid-cycle takes effect immediately.
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        total++; if (RegID_OUT !== 6'd36) begin bad++; $display("FAIL pre_async_regid got=%0d exp=36", RegID_OUT); end
        #3;
        RESET = 1'b1;
        #1;
        total++; if (RegID_OUT !== 6'd34) begin bad++; $display("FAIL async_reset_regid got=%0d exp=34", RegID_OUT); end
        total++; if (FREE_COUNT_OUT !== 6'd30) begin bad++; $display("FAIL async_reset_count got=%0d exp=30", FREE_COUNT_OUT); end
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic test_drain();
        do_reset();
        drive(1, 1, 0, 0, 0, 0);  // stalled: no grant
        total++; if (FREE_COUNT_OUT !== 6'd30) begin bad++; $display("FAIL stall_count got=%0d exp=30", FREE_COUNT_OUT); end
        for (int k = 0; k < 30; k++) begin
            total++;
            if (RegID_OUT !== 6'(34 + k)) begin
                bad++; $display("FAIL drain_regid[%0d] got=%0d exp=%0d", k, RegID_OUT, 34 + k);
            end
            drive(1, 0, 0, 0, 0, 0);
        end
        total++; if (EMPTY_OUT !== 1'b1) begin bad++; $display("FAIL drain_empty got=%0b exp=1", EMPTY_OUT); end
        total++; if (FREE_COUNT_OUT !== 6'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", FREE_COUNT_OUT); end
        drive(1, 0, 0, 0, 0, 0);  // alloc while empty: ignored, no error
        total++; if (OVERFLOW_OUT !== 1'b0) begin bad++; $display("FAIL empty_alloc_ovf got=%0b exp=0", OVERFLOW_OUT); end
        total++; if (FREE_COUNT_OUT !== 6'd0) begin bad++; $display("FAIL empty_alloc_count got=%0d exp=0", FREE_COUNT_OUT); end
    endtask

    task automatic test_release_empty();
        // Continues from the drained state.
        drive(1, 0, 1, 6'd5, 0, 0);
        total++; if (FREE_COUNT_OUT !== 6'd1) begin bad++; $display("FAIL rel_empty_count got=%0d exp=1", FREE_COUNT_OUT); end
        total++; if (RegID_OUT !== 6'd5) begin bad++; $display("FAIL rel_empty_regid got=%0d exp=5", RegID_OUT); end
        total++; if (EMPTY_OUT !== 1'b0) begin bad++; $display("FAIL rel_empty_empty got=%0b exp=0", EMPTY_OUT); end
    endtask

    task automatic test_flush();
        do_reset();
        repeat (3) drive(1, 0, 0, 0, 0, 0);
        total++; if (FREE_COUNT_OUT !== 6'd27) begin bad++; $display("FAIL flush_pre_count got=%0d exp=27", FREE_COUNT_OUT); end
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1);
        total++; if (RegID_OUT !== 6'd35) begin bad++; $display("FAIL flush_regid got=%0d exp=35", RegID_OUT); end
        total++; if (FREE_COUNT_OUT !== 6'd29) begin bad++; $display("FAIL flush_count got=%0d exp=29", FREE_COUNT_OUT); end
    endtask

    task automatic test_flush_commit();
        do_reset();
        repeat (3) drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 1, 1);  // flush beats alloc; includes this commit
        total++; if (RegID_OUT !== 6'd36) begin bad++; $display("FAIL flush_commit_regid got=%0d exp=36", RegID_OUT); end
        total++; if (FREE_COUNT_OUT !== 6'd28) begin bad++; $display("FAIL flush_commit_count got=%0d exp=28", FREE_COUNT_OUT); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 40; k++) begin
            if (k % 2 == 0) begin
                drive(0, 0, 1, 6'(k * 3 + 1), 0, 0);
            end else begin
                total++;
                if (RegID_OUT !== free_q[0]) begin
                    bad++; $display("FAIL wrap_regid[%0d] got=%0d exp=%0d", k, RegID_OUT, free_q[0]);
                end
                drive(1, 0, 0, 0, 0, 0);
            end
        end
        total++;
        if (FREE_COUNT_OUT !== 6'(free_q.size())) begin
            bad++; $display("FAIL wrap_count got=%0d exp=%0d", FREE_COUNT_OUT, free_q.size());
        end
        // Drain: remaining reset IDs, then released IDs in release order.
        while (free_q.size() > 0) begin
            total++;
            if (RegID_OUT !== free_q[0]) begin
                bad++; $display("FAIL wrap_drain got=%0d exp=%0d", RegID_OUT, free_q[0]);
            end
            drive(1, 0, 0, 0, 0, 0);
        end
        total++; if (EMPTY_OUT !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%0b exp=1", EMPTY_OUT); end
    endtask

    task automatic test_overflow();
        do_reset();
        drive(0, 0, 1, 6'd1, 0, 0);
        drive(0, 0, 1, 6'd2, 0, 0);
        total++; if (FREE_COUNT_OUT !== 6'd32) begin bad++; $display("FAIL full_count got=%0d exp=32", FREE_COUNT_OUT); end
        total++; if (OVERFLOW_OUT !== 1'b0) begin bad++; $display("FAIL full_ovf got=%0b exp=0", OVERFLOW_OUT); end
        drive(0, 0, 1, 6'd3, 0, 0);
        total++; if (OVERFLOW_OUT !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0b exp=1", OVERFLOW_OUT); end
        total++; if (FREE_COUNT_OUT !== 6'd32) begin bad++; $display("FAIL ovf_count got=%0d exp=32", FREE_COUNT_OUT); end
        drive(1, 0, 0, 0, 0, 0);
        total++; if (OVERFLOW_OUT !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b exp=1", OVERFLOW_OUT); end
        total++; if (FREE_COUNT_OUT !== 6'd31) begin bad++; $display("FAIL ovf_alloc_count got=%0d exp=31", FREE_COUNT_OUT); end
        do_reset();
        total++; if (OVERFLOW_OUT !== 1'b0) begin bad++; $display("FAIL ovf_reset got=%0b exp=0", OVERFLOW_OUT); end
    endtask

    task automatic test_random();
        logic a, s, r, c, f;
        logic [5:0] rid;
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            a   = 1'($urandom_range(0, 1));
            s   = ($urandom_range(0, 3) == 0);
            c   = (inflight_q.size() > 0) && ($urandom_range(0, 2) == 0);
            r   = (pool_q.size() > 0) && ($urandom_range(0, 2) == 0);
            f   = ($urandom_range(0, 15) == 0);
            rid = r ? pool_q.pop_front() : 6'd0;
            drive(a, s, r, rid, c, f);
            total++;
            if (FREE_COUNT_OUT !== 6'(free_q.size()) || EMPTY_OUT !== (free_q.size() == 0)
                || OVERFLOW_OUT !== m_ovf) begin
                bad++;
                $display("FAIL rand_state[%0d] count=%0d/%0d empty=%0b ovf=%0b/%0b", n,
                         FREE_COUNT_OUT, free_q.size(), EMPTY_OUT, OVERFLOW_OUT, m_ovf);
            end
            if (free_q.size() > 0) begin
                total++;
                if (RegID_OUT !== free_q[0]) begin
                    bad++; $display("FAIL rand_regid[%0d] got=%0d exp=%0d", n, RegID_OUT, free_q[0]);
                end
            end
        end
    endtask

    initial begin
        RESET = 1'b1;
        test_reset();
        test_drain();
        test_release_empty();
        test_flush();
        test_flush_commit();
        test_wrap();
        test_overflow();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
